// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response handshakes for two requesters plus the
// shared ALU drive/result bus and arbiter status.
// slave  = arbiter side, master = requesters/ALU/environment side.
interface alu_arbiter_if;
  logic        REQ0_VLD, REQ0_RDY, REQ1_VLD, REQ1_RDY;
  logic [31:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic [4:0]  REQ0_OPC, REQ0_SHFT, REQ1_OPC, REQ1_SHFT;
  logic        REQ0_CIN, REQ1_CIN;

  logic        RSP0_VLD, RSP0_RDY, RSP1_VLD, RSP1_RDY;
  logic [31:0] RSP_RSLT;
  logic [3:0]  RSP_FLG;
  logic        RSP_ERR;

  logic        ALU_EN;
  logic [31:0] ALU_A, ALU_B;
  logic [4:0]  ALU_OPC, ALU_SHFT;
  logic        ALU_CIN;
  logic [31:0] ALU_RSLT;
  logic        ALU_ZR, ALU_OFLW, ALU_COUT, ALU_NEG;

  logic        BUSY, GNT_ID;

  modport slave (
    input  REQ0_VLD, REQ1_VLD, REQ0_A, REQ0_B, REQ1_A, REQ1_B,
           REQ0_OPC, REQ0_SHFT, REQ1_OPC, REQ1_SHFT, REQ0_CIN, REQ1_CIN,
           RSP0_RDY, RSP1_RDY,
           ALU_RSLT, ALU_ZR, ALU_OFLW, ALU_COUT, ALU_NEG,
    output REQ0_RDY, REQ1_RDY, RSP0_VLD, RSP1_VLD, RSP_RSLT, RSP_FLG, RSP_ERR,
           ALU_EN, ALU_A, ALU_B, ALU_OPC, ALU_SHFT, ALU_CIN,
           BUSY, GNT_ID
  );

  modport master (
    output REQ0_VLD, REQ1_VLD, REQ0_A, REQ0_B, REQ1_A, REQ1_B,
           REQ0_OPC, REQ0_SHFT, REQ1_OPC, REQ1_SHFT, REQ0_CIN, REQ1_CIN,
           RSP0_RDY, RSP1_RDY,
           ALU_RSLT, ALU_ZR, ALU_OFLW, ALU_COUT, ALU_NEG,
    input  REQ0_RDY, REQ1_RDY, RSP0_VLD, RSP1_VLD, RSP_RSLT, RSP_FLG, RSP_ERR,
           ALU_EN, ALU_A, ALU_B, ALU_OPC, ALU_SHFT, ALU_CIN,
           BUSY, GNT_ID
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter in front of a shared multi-cycle ALU.
// One requester owns the ALU from grant until its response is accepted.
// Optional feature macro: ALU_ARB_ROUND_ROBIN_EN
//   defined   -> round-robin, last-granted requester loses ties
//   undefined -> fixed priority, requester 0 always wins
//
// state | meaning
// IDLE  | no owner; a pending request is granted combinationally
// EXEC  | ALU enabled with latched operands, latency counter running
// RESP  | response held for the owner until it accepts it
module alu_arbiter #(
  parameter int ALU_LAT = 1  // cycles of ALU_EN before result is valid, 1..4
) (
  input  logic     CLK,
  input  logic     RST,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [2:0] LAT_LD = 3'(ALU_LAT);
  localparam logic [4:0] OPC_MAX = 5'd9;  // SLTU, last legal opcode

  state_t     state, state_nxt;
  logic [2:0] cnt;
  logic       any_vld, grant, gnt_sel, gnt_nxt, opc_ok, hs, exec_done;
  logic [4:0] sel_opc;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic rr_last;

  // remember the last granted requester; reset value lets requester 0 win first
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)       rr_last <= 1'b1;
    else if (grant) rr_last <= gnt_sel;
  end

  // round-robin pick: on a tie the requester not granted last time wins
  always_comb begin
    if (bus.REQ0_VLD && bus.REQ1_VLD) gnt_sel = ~rr_last;
    else                              gnt_sel = bus.REQ1_VLD;
  end
`else
  // fixed priority pick: requester 1 only when requester 0 is idle
  always_comb gnt_sel = ~bus.REQ0_VLD;
`endif

  // grant qualification, opcode legality and owner handshake
  always_comb begin
    any_vld   = bus.REQ0_VLD | bus.REQ1_VLD;
    grant     = (state == IDLE) && any_vld;
    sel_opc   = gnt_sel ? bus.REQ1_OPC : bus.REQ0_OPC;
    opc_ok    = (sel_opc <= OPC_MAX);
    hs        = bus.GNT_ID ? bus.RSP1_RDY : bus.RSP0_RDY;
    gnt_nxt   = grant ? gnt_sel : bus.GNT_ID;
    exec_done = (state == EXEC) && (cnt <= 3'd1);
  end

  // state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // next-state logic; illegal opcodes bypass EXEC
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_vld) state_nxt = opc_ok ? EXEC : RESP;
      EXEC:    if (exec_done) state_nxt = RESP;
      RESP:    if (hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // request ready is the only combinational output: high in the grant cycle
  always_comb begin
    bus.REQ0_RDY = grant && !gnt_sel;
    bus.REQ1_RDY = grant &&  gnt_sel;
  end

  // registered control outputs derived from the upcoming state, plus latency counter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus.BUSY     <= 1'b0;
      bus.ALU_EN   <= 1'b0;
      bus.RSP0_VLD <= 1'b0;
      bus.RSP1_VLD <= 1'b0;
      bus.GNT_ID   <= 1'b0;
      cnt          <= 3'd0;
    end else begin
      bus.BUSY     <= (state_nxt != IDLE);
      bus.ALU_EN   <= (state_nxt == EXEC);
      bus.RSP0_VLD <= (state_nxt == RESP) && !gnt_nxt;
      bus.RSP1_VLD <= (state_nxt == RESP) &&  gnt_nxt;
      bus.GNT_ID   <= gnt_nxt;
      if (grant)              cnt <= opc_ok ? LAT_LD : 3'd0;
      else if (state == EXEC) cnt <= cnt - 3'd1;
    end
  end

  // latch the winner's operands on the grant edge; held stable through EXEC
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus.ALU_A    <= 32'd0;
      bus.ALU_B    <= 32'd0;
      bus.ALU_OPC  <= 5'd0;
      bus.ALU_SHFT <= 5'd0;
      bus.ALU_CIN  <= 1'b0;
    end else if (grant) begin
      bus.ALU_A    <= gnt_sel ? bus.REQ1_A    : bus.REQ0_A;
      bus.ALU_B    <= gnt_sel ? bus.REQ1_B    : bus.REQ0_B;
      bus.ALU_OPC  <= sel_opc;
      bus.ALU_SHFT <= gnt_sel ? bus.REQ1_SHFT : bus.REQ0_SHFT;
      bus.ALU_CIN  <= gnt_sel ? bus.REQ1_CIN  : bus.REQ0_CIN;
    end
  end

  // response capture: error response on illegal grant, ALU result at end of EXEC
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus.RSP_RSLT <= 32'd0;
      bus.RSP_FLG  <= 4'd0;
      bus.RSP_ERR  <= 1'b0;
    end else if (grant && !opc_ok) begin
      bus.RSP_RSLT <= 32'd0;
      bus.RSP_FLG  <= 4'd0;
      bus.RSP_ERR  <= 1'b1;
    end else if (exec_done) begin
      bus.RSP_RSLT <= bus.ALU_RSLT;
      bus.RSP_FLG  <= {bus.ALU_ZR, bus.ALU_OFLW, bus.ALU_COUT, bus.ALU_NEG};
      bus.RSP_ERR  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed, table-driven checks of alu_arbiter.
// Two DUT instances (ALU_LAT=1 and ALU_LAT=3) share stimulus; sel picks the
// active one. A behavioural ALU per instance only presents a valid result in
// the last cycle of its latency window.
module tb_alu_arbiter;

  typedef struct packed {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  opc;
    logic [4:0]  shft;
    logic        cin;
    logic [31:0] rslt;
    logic [3:0]  flg;
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sel;
  logic [1:0]  req_vld, rsp_rdy, req_cin;
  logic [31:0] req_a [2];
  logic [31:0] req_b [2];
  logic [4:0]  req_opc [2];
  logic [4:0]  req_shft [2];

  int errors = 0;
  int checks = 0;

  alu_arbiter_if b1();
  alu_arbiter_if b3();

  alu_arbiter #(.ALU_LAT(1)) dut1 (.CLK(clk), .RST(rst), .bus(b1));
  alu_arbiter #(.ALU_LAT(3)) dut3 (.CLK(clk), .RST(rst), .bus(b3));

  assign b1.REQ0_VLD = req_vld[0] & ~sel;
  assign b1.REQ1_VLD = req_vld[1] & ~sel;
  assign b3.REQ0_VLD = req_vld[0] & sel;
  assign b3.REQ1_VLD = req_vld[1] & sel;
  assign b1.RSP0_RDY = rsp_rdy[0] & ~sel;
  assign b1.RSP1_RDY = rsp_rdy[1] & ~sel;
  assign b3.RSP0_RDY = rsp_rdy[0] & sel;
  assign b3.RSP1_RDY = rsp_rdy[1] & sel;
  assign b1.REQ0_A = req_a[0];    assign b3.REQ0_A = req_a[0];
  assign b1.REQ1_A = req_a[1];    assign b3.REQ1_A = req_a[1];
  assign b1.REQ0_B = req_b[0];    assign b3.REQ0_B = req_b[0];
  assign b1.REQ1_B = req_b[1];    assign b3.REQ1_B = req_b[1];
  assign b1.REQ0_OPC = req_opc[0];  assign b3.REQ0_OPC = req_opc[0];
  assign b1.REQ1_OPC = req_opc[1];  assign b3.REQ1_OPC = req_opc[1];
  assign b1.REQ0_SHFT = req_shft[0];  assign b3.REQ0_SHFT = req_shft[0];
  assign b1.REQ1_SHFT = req_shft[1];  assign b3.REQ1_SHFT = req_shft[1];
  assign b1.REQ0_CIN = req_cin[0];  assign b3.REQ0_CIN = req_cin[0];
  assign b1.REQ1_CIN = req_cin[1];  assign b3.REQ1_CIN = req_cin[1];

  // behavioural ALU: {rslt, ZR, OFLW, COUT, NEG}
  function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] opc, input logic [4:0] sh,
                                        input logic cin);
    logic [32:0] s;
    logic [31:0] r;
    logic ov, co;
    s = 33'd0; ov = 1'b0; co = 1'b0;
    case (opc)
      5'd0: begin
        s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        r = s[31:0]; co = s[32]; ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      5'd1: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[31:0]; co = s[32]; ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      5'd2: r = a & b;
      5'd3: r = a | b;
      5'd4: r = a ^ b;
      5'd5: r = a << sh;
      5'd6: r = a >> sh;
      5'd7: r = $signed(a) >>> sh;
      5'd8: r = {31'd0, $signed(a) < $signed(b)};
      5'd9: r = {31'd0, a < b};
      default: r = 32'd0;
    endcase
    return {r, (r == 32'd0), ov, co, r[31]};
  endfunction

  localparam logic [35:0] JUNK = {32'hDEADBEEF, 4'b1111};

  int en1, en3;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin en1 <= 0; en3 <= 0; end
    else begin
      en1 <= b1.ALU_EN ? en1 + 1 : 0;
      en3 <= b3.ALU_EN ? en3 + 1 : 0;
    end
  end

  logic [35:0] m1, m3;
  assign m1 = (b1.ALU_EN && en1 == 0) ? alu_f(b1.ALU_A, b1.ALU_B, b1.ALU_OPC, b1.ALU_SHFT, b1.ALU_CIN) : JUNK;
  assign m3 = (b3.ALU_EN && en3 == 2) ? alu_f(b3.ALU_A, b3.ALU_B, b3.ALU_OPC, b3.ALU_SHFT, b3.ALU_CIN) : JUNK;
  assign b1.ALU_RSLT = m1[35:4];
  assign {b1.ALU_ZR, b1.ALU_OFLW, b1.ALU_COUT, b1.ALU_NEG} = m1[3:0];
  assign b3.ALU_RSLT = m3[35:4];
  assign {b3.ALU_ZR, b3.ALU_OFLW, b3.ALU_COUT, b3.ALU_NEG} = m3[3:0];

  // view of the selected instance
  wire [1:0]  o_req_rdy = sel ? {b3.REQ1_RDY, b3.REQ0_RDY} : {b1.REQ1_RDY, b1.REQ0_RDY};
  wire [1:0]  o_rsp_vld = sel ? {b3.RSP1_VLD, b3.RSP0_VLD} : {b1.RSP1_VLD, b1.RSP0_VLD};
  wire [31:0] o_rslt    = sel ? b3.RSP_RSLT : b1.RSP_RSLT;
  wire [3:0]  o_flg     = sel ? b3.RSP_FLG  : b1.RSP_FLG;
  wire        o_err     = sel ? b3.RSP_ERR  : b1.RSP_ERR;
  wire        o_alu_en  = sel ? b3.ALU_EN   : b1.ALU_EN;
  wire        o_busy    = sel ? b3.BUSY     : b1.BUSY;
  wire        o_gnt     = sel ? b3.GNT_ID   : b1.GNT_ID;
  wire [31:0] o_alu_a   = sel ? b3.ALU_A    : b1.ALU_A;
  wire [31:0] o_alu_b   = sel ? b3.ALU_B    : b1.ALU_B;
  wire [4:0]  o_alu_opc = sel ? b3.ALU_OPC  : b1.ALU_OPC;
  wire [4:0]  o_alu_sh  = sel ? b3.ALU_SHFT : b1.ALU_SHFT;
  wire        o_alu_cin = sel ? b3.ALU_CIN  : b1.ALU_CIN;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_alu_en"}, 32'(o_alu_en), 32'd0);
    chk({tag, "_busy"},   32'(o_busy), 32'd0);
    chk({tag, "_gnt"},    32'(o_gnt), 32'd0);
    chk({tag, "_rsp_vld"}, 32'(o_rsp_vld), 32'd0);
    chk({tag, "_rslt"},   o_rslt, 32'd0);
    chk({tag, "_flg"},    32'(o_flg), 32'd0);
    chk({tag, "_err"},    32'(o_err), 32'd0);
    chk({tag, "_alu_a"},  o_alu_a, 32'd0);
    chk({tag, "_alu_b"},  o_alu_b, 32'd0);
    chk({tag, "_alu_opc"}, 32'({o_alu_opc, o_alu_sh, o_alu_cin}), 32'd0);
  endtask

  // reset asserted mid-cycle; outputs must clear without a clock edge
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_zero(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] opc, input logic [4:0] sh, input logic cin);
    req_a[id] = a; req_b[id] = b; req_opc[id] = opc; req_shft[id] = sh; req_cin[id] = cin;
  endtask

  // one complete transaction: grant, latency, response contents, handshake
  task automatic run_op(input vec_t v);
    int id, n, en_cnt, exp_lat;
    bit seen;
    id = int'(v.id);
    exp_lat = v.err ? 1 : (sel ? 4 : 2);
    @(posedge clk); #1;
    set_req(id, v.a, v.b, v.opc, v.shft, v.cin);
    req_vld[id] = 1'b1;
    @(negedge clk);
    chk("grant_rdy", 32'(o_req_rdy[id]), 32'd1);
    chk("other_rdy", 32'(o_req_rdy[1-id]), 32'd0);
    @(posedge clk); #1;
    req_vld[id] = 1'b0;
    n = 1; en_cnt = 0; seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (o_alu_en) en_cnt++;
      if (o_rsp_vld[id]) seen = 1'b1;
      else n++;
    end
    chk("rsp_latency", 32'(n), 32'(exp_lat));
    chk("alu_en_cycles", 32'(en_cnt), v.err ? 32'd0 : (sel ? 32'd3 : 32'd1));
    chk("rsp_rslt", o_rslt, v.rslt);
    chk("rsp_flg", 32'(o_flg), 32'(v.flg));
    chk("rsp_err", 32'(o_err), 32'(v.err));
    chk("gnt_id", 32'(o_gnt), 32'(v.id));
    chk("other_rsp_vld", 32'(o_rsp_vld[1-id]), 32'd0);
    chk("busy_resp", 32'(o_busy), 32'd1);
    rsp_rdy[id] = 1'b1;
    @(posedge clk); #1;
    rsp_rdy[id] = 1'b0;
    @(negedge clk);
    chk("rsp_vld_drop", 32'(o_rsp_vld), 32'd0);
    chk("busy_idle", 32'(o_busy), 32'd0);
  endtask

  vec_t vt [10];
  int   exp_g [3];
  int   g;
  bit   got;
  int   cnt_v;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //            id  a             b             opc    sh     cin   rslt          flg      err
    vt[0] = '{1'b0, 32'd5,        32'd4,        5'd0,  5'd0,  1'b1, 32'h0000000A, 4'b0000, 1'b0};
    vt[1] = '{1'b1, 32'h7FFFFFFF, 32'd1,        5'd0,  5'd0,  1'b0, 32'h80000000, 4'b0101, 1'b0};
    vt[2] = '{1'b1, 32'd3,        32'd3,        5'h1F, 5'd0,  1'b0, 32'h00000000, 4'b0000, 1'b1};
    vt[3] = '{1'b0, 32'd3,        32'd3,        5'd1,  5'd0,  1'b0, 32'h00000000, 4'b1000, 1'b0};
    vt[4] = '{1'b0, 32'd0,        32'd1,        5'd1,  5'd0,  1'b0, 32'hFFFFFFFF, 4'b0011, 1'b0};
    vt[5] = '{1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 5'd4,  5'd0,  1'b0, 32'h0FF00FF0, 4'b0000, 1'b0};
    vt[6] = '{1'b0, 32'd1,        32'd0,        5'd5,  5'd31, 1'b0, 32'h80000000, 4'b0001, 1'b0};
    vt[7] = '{1'b0, 32'd7,        32'd8,        5'd10, 5'd0,  1'b0, 32'h00000000, 4'b0000, 1'b1};
    vt[8] = '{1'b1, 32'd1,        32'hFFFFFFFF, 5'd9,  5'd0,  1'b0, 32'h00000001, 4'b0000, 1'b0};
    vt[9] = '{1'b0, 32'hFFFFFFFF, 32'd1,        5'd0,  5'd0,  1'b0, 32'h00000000, 4'b1010, 1'b0};
`ifdef ALU_ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0};
`else
    exp_g = '{0, 0, 0};
`endif

    rst = 1'b1; sel = 1'b0;
    req_vld = 2'b00; rsp_rdy = 2'b00; req_cin = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_a[i] = 32'd0; req_b[i] = 32'd0; req_opc[i] = 5'd0; req_shft[i] = 5'd0;
    end
    do_reset("rst_init");

    // directed vectors, ALU_LAT=1
    for (int i = 0; i < 10; i++) run_op(vt[i]);

    // simultaneous requests held for three operations
    do_reset("rst_arb");
    @(posedge clk); #1;
    set_req(0, 32'd1, 32'd1, 5'd0, 5'd0, 1'b0);
    set_req(1, 32'd2, 32'd2, 5'd0, 5'd0, 1'b0);
    req_vld = 2'b11;
    for (int op = 0; op < 3; op++) begin
      got = 1'b0; g = 0;
      for (int k = 0; k < 10 && !got; k++) begin
        @(negedge clk);
        if (o_req_rdy != 2'b00) begin
          got = 1'b1;
          g = o_req_rdy[1] ? 1 : 0;
          chk("arb_onehot", 32'($countones(o_req_rdy)), 32'd1);
        end
      end
      chk("arb_grant_seen", 32'(got), 32'd1);
      chk("arb_grant_id", 32'(g), 32'(exp_g[op]));
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
        @(negedge clk);
        chk("arb_no_rdy_busy", 32'(o_req_rdy), 32'd0);
        if (o_rsp_vld[g]) got = 1'b1;
      end
      chk("arb_rsp_seen", 32'(got), 32'd1);
      chk("arb_rslt", o_rslt, (g == 1) ? 32'd4 : 32'd2);
      rsp_rdy[g] = 1'b1;
      @(posedge clk); #1;
      rsp_rdy[g] = 1'b0;
      if (op == 2) req_vld = 2'b00;
    end

    // response back-pressure with a waiting second requester
    @(posedge clk); #1;
    set_req(0, 32'd10, 32'd20, 5'd0, 5'd0, 1'b0);
    req_vld[0] = 1'b1;
    @(negedge clk);
    chk("bp_gnt0", 32'(o_req_rdy[0]), 32'd1);
    @(posedge clk); #1;
    req_vld[0] = 1'b0;
    set_req(1, 32'd100, 32'd1, 5'd0, 5'd0, 1'b0);
    req_vld[1] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      chk("bp_req1_wait", 32'(o_req_rdy[1]), 32'd0);
      if (o_rsp_vld[0]) got = 1'b1;
    end
    chk("bp_rsp0_seen", 32'(got), 32'd1);
    rsp_rdy[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_vld", 32'(o_rsp_vld), 32'd1);
      chk("bp_hold_rslt", o_rslt, 32'h0000001E);
      chk("bp_hold_flg", 32'({o_flg, o_err}), 32'd0);
      chk("bp_hold_req1", 32'(o_req_rdy[1]), 32'd0);
    end
    @(posedge clk); #1;
    rsp_rdy = 2'b01;
    @(negedge clk);
    chk("bp_hs_req1", 32'(o_req_rdy[1]), 32'd0);
    @(posedge clk); #1;
    rsp_rdy = 2'b00;
    @(negedge clk);
    chk("bp_after_req1", 32'(o_req_rdy[1]), 32'd1);
    chk("bp_after_vld", 32'(o_rsp_vld), 32'd0);
    @(posedge clk); #1;
    req_vld[1] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (o_rsp_vld[1]) got = 1'b1;
    end
    chk("bp_rsp1_seen", 32'(got), 32'd1);
    chk("bp_rsp1_rslt", o_rslt, 32'h00000065);
    chk("bp_rsp1_gnt", 32'(o_gnt), 32'd1);
    rsp_rdy[1] = 1'b1;
    @(posedge clk); #1;
    rsp_rdy[1] = 1'b0;

    // reset in the middle of a ALU_LAT=3 operation
    sel = 1'b1;
    @(posedge clk); #1;
    set_req(1, 32'd9, 32'd9, 5'd0, 5'd0, 1'b0);
    req_vld[1] = 1'b1;
    @(negedge clk);
    chk("rx_gnt1", 32'(o_req_rdy[1]), 32'd1);
    @(posedge clk); #1;
    req_vld[1] = 1'b0;
    @(negedge clk);
    chk("rx_exec_en", 32'(o_alu_en), 32'd1);
    chk("rx_exec_a", o_alu_a, 32'd9);
    chk("rx_exec_gnt", 32'(o_gnt), 32'd1);
    do_reset("rx_rst");
    cnt_v = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (o_rsp_vld != 2'b00 || o_busy) cnt_v++;
    end
    chk("rx_no_rsp", 32'(cnt_v), 32'd0);
    run_op('{1'b0, 32'd6, 32'd7, 5'd0, 5'd0, 1'b0, 32'h0000000D, 4'b0000, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
